stopwatch: RTL
==============

STOPWATCH -- requirements
Module: stopwatch

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning CLOCK_50 cycles per counted second (benches override to a small value).
REQ-002 SHALL have port CLOCK_50  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_btn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_btn  input  1  pushbutton, active-low, asynchronous to CLOCK_50; press means start/pause.
REQ-005 SHALL have port lap_btn  input  1  pushbutton, active-low, asynchronous; press means lap/clear.
REQ-006 SHALL have port disp_d0  output  4  BCD seconds units shown.
REQ-007 SHALL have port disp_d1  output  4  BCD seconds tens shown.
REQ-008 SHALL have port disp_d2  output  4  BCD minutes units shown.
REQ-009 SHALL have port disp_d3  output  4  BCD minutes tens shown.
REQ-010 SHALL have port state  output  3  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4.
REQ-011 SHALL have port ledr  output  10  all bits equal the flash bit in FULL, else 0.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on each counted second.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a falling-edge detector; one press = one event, however long it is held.
REQ-014 SHALL make the state change 3 rising edges after the first edge at which the button is sampled low.
REQ-015 SHALL run the prescaler 0..TICKS_PER_SEC-1 only in RUN, LAP and FULL, wrapping to 0, with tick asserted in the cycle the prescaler equals TICKS_PER_SEC-1.
REQ-016 SHALL hold the prescaler in PAUSE, so a resume keeps the partial second, and clear it to 0 on IDLE->RUN.
REQ-017 SHALL hold the live time as 4 BCD digits mm:ss, range 00:00..99:59.
REQ-018 SHALL increment the live time by 1 s on each tick in RUN or LAP, with carries: seconds units 9->0 carries; seconds tens 5->0 carries; minutes units 9->0 carries; minutes tens increments.
REQ-019 SHALL, on a tick at 99:59, hold the time at 99:59 and enter FULL.
REQ-020 SHALL implement these transitions: IDLE+start->RUN; RUN+start->PAUSE; RUN+lap->LAP; LAP+lap->RUN; LAP+start->PAUSE; PAUSE+start->RUN; PAUSE+lap->IDLE with time cleared to 00:00; FULL+lap->IDLE with time cleared to 00:00; FULL+start ignored; IDLE+lap ignored.
REQ-021 SHALL, on RUN->LAP, capture the live time at that edge (the value before any same-edge increment) into the lap register.
REQ-022 SHALL drive disp_d* from the lap register in LAP, and from the live time in all other states.
REQ-023 SHALL resolve simultaneous start and lap events as start; lap is discarded.
REQ-024 SHALL still apply a tick that coincides with a RUN->PAUSE or LAP->PAUSE event.
REQ-025 SHALL toggle the flash bit on each tick in FULL, and set it to 0 on entry to FULL.
REQ-026 SHALL never produce a non-BCD digit, and never a seconds-tens digit above 5.

Reset
REQ-027 SHALL, at a rising edge with reset_btn=0, set state=IDLE; live time, lap register and disp_d*=0; prescaler=0; flash=0; tick=0; ledr=0; synchronizer flops=1 (released).
REQ-028 SHALL let reset override everything, including mid-RUN, in FULL, and simultaneous button events.
REQ-029 SHALL not generate a button event from the first cycle after reset if the button is already held low.

Verification (TICKS_PER_SEC=4)
REQ-030 SHALL cover: reset, start press, 40 cycles -> state=1, time 00:10 (±1 s for press latency), tick period 4 cycles.
REQ-031 SHALL cover: RUN at 00:05, start press, 100 cycles -> time frozen at 00:05 and prescaler unchanged; start again -> resumes at the held fraction.
REQ-032 SHALL cover: RUN at 00:07, lap press -> disp shows 00:07 while live time advances to 00:12; lap again -> disp shows live 00:12+.
REQ-033 SHALL cover: live time forced to 99:58 via run -> after 2 ticks, state=4, disp 99:59, ledr toggles 0x3FF/0x000 each tick; lap -> state=0, 00:00.
REQ-034 SHALL cover: start and lap pressed on the same cycle in RUN -> state=2, lap discarded; start held 50 cycles -> exactly one event.
REQ-035 SHALL cover: reset_btn low for one cycle during LAP -> next cycle state=0, all outputs 0.

Source files
------------

// File: rtl/stopwatch.sv
// stopwatch: mm:ss stopwatch with start/pause, lap hold and overflow flash
//   CLOCK_50             clock, all logic on its rising edge
//   reset_btn            synchronous active-low reset
//   start_btn            active-low asynchronous pushbutton: start / pause
//   lap_btn              active-low asynchronous pushbutton: lap / clear
//   disp_d0..disp_d3     BCD seconds units, seconds tens, minutes units, minutes tens
//   state                IDLE=0 RUN=1 PAUSE=2 LAP=3 FULL=4
//   ledr                 all bits follow the flash bit while FULL
//   tick                 one-cycle pulse on each counted second
module stopwatch #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_btn,
  input  logic       start_btn,
  input  logic       lap_btn,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic [2:0] state,
  output logic [9:0] ledr,
  output logic       tick
);
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, LAP = 3'd3, FULL = 3'd4;
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  logic [2:0] st_q, st_d, ss_q, ss_d, ls_q, ls_d;
  logic [1:0] warm_q, warm_d, ev_q, ev_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] tm_q, tm_d, lap_q, lap_d, tm_inc;
  logic flash_q, flash_d, active, counting, start_ev, lap_ev, c0, c1, c2;
  always_comb begin
    ss_d = {ss_q[1:0], start_btn};
    ls_d = {ls_q[1:0], lap_btn};
    warm_d = warm_q == 2'd3 ? warm_q : warm_q + 2'd1;
    // edges count only once the oldest stage holds a real post-reset sample, so a button held through reset is ignored
    ev_d = warm_q == 2'd3 ? {ls_q[2] & ~ls_q[1], ss_q[2] & ~ss_q[1]} : 2'b00;
    start_ev = ev_q[0];
    lap_ev = ev_q[1] & ~ev_q[0];
    active = st_q == RUN || st_q == LAP || st_q == FULL;
    counting = st_q == RUN || st_q == LAP;
    tick = active && pre_q == PMAX;
    pre_d = active ? (tick ? '0 : pre_q + PW'(1)) : (st_q == IDLE && start_ev) ? '0 : pre_q;
    c0 = tm_q[3:0] == 4'd9;
    c1 = c0 && tm_q[7:4] == 4'd5;
    c2 = c1 && tm_q[11:8] == 4'd9;
    tm_inc = {c2 ? tm_q[15:12] + 4'd1 : tm_q[15:12],
              c2 ? 4'd0 : c1 ? tm_q[11:8] + 4'd1 : tm_q[11:8],
              c1 ? 4'd0 : c0 ? tm_q[7:4] + 4'd1 : tm_q[7:4],
              c0 ? 4'd0 : tm_q[3:0] + 4'd1};
    st_d = st_q;
    tm_d = tm_q;
    lap_d = lap_q;
    flash_d = flash_q;
    case (st_q)
      IDLE:  st_d = start_ev ? RUN : IDLE;
      RUN: begin
        st_d = start_ev ? PAUSE : lap_ev ? LAP : RUN;
        lap_d = lap_ev ? tm_q : lap_q;
      end
      LAP:   st_d = start_ev ? PAUSE : lap_ev ? RUN : LAP;
      PAUSE: st_d = start_ev ? RUN : lap_ev ? IDLE : PAUSE;
      FULL:  st_d = lap_ev ? IDLE : FULL;
      default: st_d = IDLE;
    endcase
    if ((st_q == PAUSE || st_q == FULL) && lap_ev) tm_d = 16'h0000;
    // a tick at 99:59 saturates and wins over any same-edge button transition
    if (counting && tick) begin
      if (tm_q == 16'h9959) begin
        st_d = FULL;
        flash_d = 1'b0;
      end else tm_d = tm_inc;
    end
    if (st_q == FULL && tick) flash_d = ~flash_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset_btn) begin
      st_q <= IDLE;
      ss_q <= '1;
      ls_q <= '1;
      warm_q <= '0;
      ev_q <= '0;
      pre_q <= '0;
      tm_q <= '0;
      lap_q <= '0;
      flash_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ss_q <= ss_d;
      ls_q <= ls_d;
      warm_q <= warm_d;
      ev_q <= ev_d;
      pre_q <= pre_d;
      tm_q <= tm_d;
      lap_q <= lap_d;
      flash_q <= flash_d;
    end
  end
  assign {disp_d3, disp_d2, disp_d1, disp_d0} = st_q == LAP ? lap_q : tm_q;
  assign state = st_q;
  assign ledr = {10{st_q == FULL && flash_q}};
endmodule
